// File: rtl/rename_pkg.sv
// Shared types and sizing for the register-rename stage.
// The module parameters of rename_map_ckpt default to the constants below
// and must agree with them, because the checkpoint record type is built from
// these constants.
package rename_pkg;

    localparam int NUM_ARCH_DEF   = 32;
    localparam int NUM_PHYS_DEF   = 64;
    localparam int CKPT_DEPTH_DEF = 4;
    localparam int ROB_TAG_W_DEF  = 5;

    localparam int ARCH_W = $clog2(NUM_ARCH_DEF);
    localparam int PHYS_W = $clog2(NUM_PHYS_DEF);

    typedef logic [ARCH_W-1:0]        arch_reg_t;
    typedef logic [PHYS_W-1:0]        phys_reg_t;
    typedef logic [ROB_TAG_W_DEF-1:0] rob_tag_t;

    // Everything a mispredict has to roll back: the speculative map plus
    // the free and ready vectors as they stood right after the branch renamed.
    typedef struct packed {
        logic [NUM_ARCH_DEF-1:0][PHYS_W-1:0] map;
        logic [NUM_PHYS_DEF-1:0]             free;
        logic [NUM_PHYS_DEF-1:0]             ready;
    } ckpt_t;

    // State right after reset: identity map, upper physical registers free,
    // every register ready.
    function automatic ckpt_t reset_state();
        ckpt_t s;
        for (int i = 0; i < NUM_ARCH_DEF; i++) begin
            s.map[i] = phys_reg_t'(i);
        end
        for (int i = 0; i < NUM_PHYS_DEF; i++) begin
            s.free[i] = (i >= NUM_ARCH_DEF);
        end
        s.ready = '1;
        return s;
    endfunction

endpackage

// File: rtl/free_list_picker.sv
// Lowest-set-bit priority encoder used to pick the next free physical
// register. found is low when no bit of req is set; idx is then 0.
module free_list_picker #(
    parameter int N = 64
) (
    input  logic [N-1:0]         req,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int W = $clog2(N);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/rename_map_ckpt.sv
// Register-rename stage with branch checkpoints.
//
// Maps architectural registers onto physical registers, reports source
// mappings with ready/producer-tag status, allocates the lowest free physical
// register for each destination write, and keeps up to CKPT_DEPTH snapshots
// of (map, free, ready) so a mispredict restores the state in one cycle.
//
// Optional build macro:
//   RENAME_WB_BYPASS_EN - a same-cycle writeback to a source's physical
//                         register makes that source read ready immediately.
//                         Without it, ready shows from the cycle after.
module rename_map_ckpt
    import rename_pkg::*;
#(
    parameter int NUM_ARCH   = NUM_ARCH_DEF,
    parameter int NUM_PHYS   = NUM_PHYS_DEF,
    parameter int CKPT_DEPTH = CKPT_DEPTH_DEF,
    parameter int ROB_TAG_W  = ROB_TAG_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ren_valid,
    output logic                 ren_ready,
    input  logic [ARCH_W-1:0]    ren_rs_arch,
    input  logic [ARCH_W-1:0]    ren_rt_arch,
    input  logic [ARCH_W-1:0]    ren_rd_arch,
    input  logic                 ren_uses_rd,
    input  logic                 ren_is_branch,
    input  logic [ROB_TAG_W-1:0] ren_rob_tag,

    output logic [PHYS_W-1:0]    rs_phy,
    output logic [PHYS_W-1:0]    rt_phy,
    output logic                 rs_rdy,
    output logic                 rt_rdy,
    output logic [ROB_TAG_W-1:0] rs_tag,
    output logic [ROB_TAG_W-1:0] rt_tag,
    output logic [PHYS_W-1:0]    rd_phy,
    output logic [PHYS_W-1:0]    rd_old_phy,

    input  logic                 wb_valid,
    input  logic [PHYS_W-1:0]    wb_phy,

    input  logic                 cm_free_valid,
    input  logic [PHYS_W-1:0]    cm_free_phy,

    input  logic                 br_valid,
    input  logic                 br_mispredict,
    output logic                 ckpt_full
);

    localparam int CW = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ckpt_t                               cur_q;
    ckpt_t                               cur_d;
    logic [NUM_PHYS-1:0][ROB_TAG_W-1:0]  tag_q;
    logic [NUM_PHYS-1:0][ROB_TAG_W-1:0]  tag_d;
    ckpt_t                               ckpt_q [CKPT_DEPTH];
    ckpt_t                               ckpt_d [CKPT_DEPTH];
    logic [CW-1:0]                       wr_ptr_q;
    logic [CW-1:0]                       rd_ptr_q;
    logic [CW:0]                         count_q;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic              pick_found;
    logic [PHYS_W-1:0] pick_idx;
    logic              ckpt_any;
    logic              mispredict;
    logic              resolve;
    logic              rd_writes;
    logic              fire;
    logic              do_alloc;
    logic              take_ckpt;
    logic              free_ok;

    free_list_picker #(
        .N (NUM_PHYS)
    ) u_picker (
        .req   (cur_q.free),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A branch result with no live checkpoint is a protocol error and is
    // dropped, so mispredict/resolve only act when count is non-zero.
    assign ckpt_any   = (count_q != '0);
    assign ckpt_full  = (count_q == (CW + 1)'(CKPT_DEPTH));
    assign mispredict = br_valid & br_mispredict & ckpt_any;
    assign resolve    = br_valid & ~br_mispredict & ckpt_any;

    // Writes to r0 are accepted but never allocate.
    assign rd_writes  = ren_uses_rd & (ren_rd_arch != '0);

    // Fullness uses the count before this cycle's resolve, so a branch
    // arriving alongside a resolve at full still stalls for one cycle.
    assign ren_ready  = ~(br_valid & br_mispredict)
                      & (~rd_writes | pick_found)
                      & (~ren_is_branch | ~ckpt_full);

    assign fire       = ren_valid & ren_ready;
    assign do_alloc   = fire & rd_writes;
    assign take_ckpt  = fire & ren_is_branch;
    assign free_ok    = cm_free_valid & (cm_free_phy != '0);

    assign rd_phy     = pick_idx;
    assign rd_old_phy = cur_q.map[ren_rd_arch];

    // ------------------------------------------------------------------
    // Source lookup
    // ------------------------------------------------------------------
    logic [1:0][ARCH_W-1:0]    src_arch;
    logic [1:0][PHYS_W-1:0]    src_map;
    logic [1:0][PHYS_W-1:0]    src_phy;
    logic [1:0]                src_rdy;
    logic [1:0][ROB_TAG_W-1:0] src_tag;

    assign src_arch[0] = ren_rs_arch;
    assign src_arch[1] = ren_rt_arch;
    assign src_map[0]  = cur_q.map[ren_rs_arch];
    assign src_map[1]  = cur_q.map[ren_rt_arch];

    // Zero-latency lookup; idle or r0 sources read as phy 0, ready, tag 0.
    always_comb begin
        src_phy = '0;
        src_rdy = '1;
        src_tag = '0;
        for (int s = 0; s < 2; s++) begin
            if (ren_valid && (src_arch[s] != '0)) begin
                src_phy[s] = src_map[s];
                src_tag[s] = tag_q[src_map[s]];
`ifdef RENAME_WB_BYPASS_EN
                src_rdy[s] = cur_q.ready[src_map[s]]
                           | (wb_valid & (wb_phy == src_map[s]));
`else
                src_rdy[s] = cur_q.ready[src_map[s]];
`endif
            end
        end
    end

    assign rs_phy = src_phy[0];
    assign rt_phy = src_phy[1];
    assign rs_rdy = src_rdy[0];
    assign rt_rdy = src_rdy[1];
    assign rs_tag = src_tag[0];
    assign rt_tag = src_tag[1];

    // ------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------
    // Base is either the live state or the oldest checkpoint on a mispredict;
    // rename, writeback and commit-free are then layered on top, and a new
    // checkpoint captures the fully updated result.
    always_comb begin
        // NOTE: blocking assignments here on purpose: each update builds on the
        // previous one within the same cycle, and every output gets a default
        // first so no latch can form.
        cur_d  = mispredict ? ckpt_q[rd_ptr_q] : cur_q;
        tag_d  = tag_q;
        ckpt_d = ckpt_q;

        if (do_alloc) begin
            cur_d.map[ren_rd_arch] = pick_idx;
            cur_d.free[pick_idx]   = 1'b0;
            cur_d.ready[pick_idx]  = 1'b0;
            tag_d[pick_idx]        = ren_rob_tag;
        end

        // Writebacks and frees go to every slot; dead slots are overwritten
        // before they can be read again, so no liveness mask is needed.
        if (wb_valid) begin
            cur_d.ready[wb_phy] = 1'b1;
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                ckpt_d[i].ready[wb_phy] = 1'b1;
            end
        end

        if (free_ok) begin
            cur_d.free[cm_free_phy] = 1'b1;
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                ckpt_d[i].free[cm_free_phy] = 1'b1;
            end
        end

        if (take_ckpt) begin
            ckpt_d[wr_ptr_q] = cur_d;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Live map, status vectors and checkpoint bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q    <= reset_state();
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            cur_q <= cur_d;
            tag_q <= tag_d;
            if (mispredict) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + CW'(take_ckpt);
                rd_ptr_q <= rd_ptr_q + CW'(resolve);
                count_q  <= count_q + (CW + 1)'(take_ckpt) - (CW + 1)'(resolve);
            end
        end
    end

    // Checkpoint storage.
    always_ff @(posedge clk) begin
        // NOTE: the slots have no reset; one is only read after a branch has
        // written it, and the pointers and count that gate that are reset.
        for (int i = 0; i < CKPT_DEPTH; i++) begin
            ckpt_q[i] <= ckpt_d[i];
        end
    end

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Self-checking bench for rename_map_ckpt: directed scenarios followed by a
// randomized run against a queue-based reference model.
// Build with RENAME_WB_BYPASS_EN defined to exercise the bypass variant.
module tb_rename_map_ckpt;

`ifdef RENAME_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ren_valid;
    logic       ren_ready;
    logic [4:0] ren_rs_arch, ren_rt_arch, ren_rd_arch;
    logic       ren_uses_rd, ren_is_branch;
    logic [4:0] ren_rob_tag;
    logic [5:0] rs_phy, rt_phy;
    logic       rs_rdy, rt_rdy;
    logic [4:0] rs_tag, rt_tag;
    logic [5:0] rd_phy, rd_old_phy;
    logic       wb_valid;
    logic [5:0] wb_phy;
    logic       cm_free_valid;
    logic [5:0] cm_free_phy;
    logic       br_valid, br_mispredict;
    logic       ckpt_full;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rename_map_ckpt dut (
        .clk           (clk),
        .rst           (rst),
        .ren_valid     (ren_valid),
        .ren_ready     (ren_ready),
        .ren_rs_arch   (ren_rs_arch),
        .ren_rt_arch   (ren_rt_arch),
        .ren_rd_arch   (ren_rd_arch),
        .ren_uses_rd   (ren_uses_rd),
        .ren_is_branch (ren_is_branch),
        .ren_rob_tag   (ren_rob_tag),
        .rs_phy        (rs_phy),
        .rt_phy        (rt_phy),
        .rs_rdy        (rs_rdy),
        .rt_rdy        (rt_rdy),
        .rs_tag        (rs_tag),
        .rt_tag        (rt_tag),
        .rd_phy        (rd_phy),
        .rd_old_phy    (rd_old_phy),
        .wb_valid      (wb_valid),
        .wb_phy        (wb_phy),
        .cm_free_valid (cm_free_valid),
        .cm_free_phy   (cm_free_phy),
        .br_valid      (br_valid),
        .br_mispredict (br_mispredict),
        .ckpt_full     (ckpt_full)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0][5:0] map;
        logic [63:0]      free;
        logic [63:0]      ready;
    } snap_t;

    snap_t            m_cur;
    logic [63:0][4:0] m_tag;
    snap_t            ck_q[$];   // oldest unresolved branch at the front

    logic       exp_found, exp_full, exp_ready;
    logic [5:0] exp_rd_phy, exp_old;
    logic [5:0] exp_rs_phy, exp_rt_phy;
    logic       exp_rs_rdy, exp_rt_rdy;
    logic [4:0] exp_rs_tag, exp_rt_tag;

    function automatic void model_eval();
        logic [5:0] p;
        exp_found  = 1'b0;
        exp_rd_phy = '0;
        for (int i = 0; i < 64; i++) begin
            if (m_cur.free[i] && !exp_found) begin
                exp_found  = 1'b1;
                exp_rd_phy = 6'(i);
            end
        end
        exp_old   = m_cur.map[ren_rd_arch];
        exp_full  = (ck_q.size() == 4);
        exp_ready = !(br_valid && br_mispredict)
                  && (!ren_uses_rd || ren_rd_arch == 0 || exp_found)
                  && (!ren_is_branch || !exp_full);
        exp_rs_phy = '0; exp_rs_rdy = 1'b1; exp_rs_tag = '0;
        exp_rt_phy = '0; exp_rt_rdy = 1'b1; exp_rt_tag = '0;
        if (ren_valid && ren_rs_arch != 0) begin
            p = m_cur.map[ren_rs_arch];
            exp_rs_phy = p;
            exp_rs_rdy = m_cur.ready[p] || (BYP && wb_valid && wb_phy == p);
            exp_rs_tag = m_tag[p];
        end
        if (ren_valid && ren_rt_arch != 0) begin
            p = m_cur.map[ren_rt_arch];
            exp_rt_phy = p;
            exp_rt_rdy = m_cur.ready[p] || (BYP && wb_valid && wb_phy == p);
            exp_rt_tag = m_tag[p];
        end
    endfunction

    function automatic void model_update();
        logic  mis, res, fire;
        snap_t t;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_cur.map[i] = 6'(i);
            m_cur.free  = {32'hFFFF_FFFF, 32'h0};
            m_cur.ready = '1;
            m_tag       = '0;
            ck_q.delete();
            return;
        end
        mis = br_valid && br_mispredict && ck_q.size() > 0;
        res = br_valid && !br_mispredict && ck_q.size() > 0;
        model_eval();
        fire = ren_valid && exp_ready;
        if (mis) begin
            m_cur = ck_q[0];
            ck_q.delete();
        end
        if (fire && ren_uses_rd && ren_rd_arch != 0) begin
            m_cur.map[ren_rd_arch]  = exp_rd_phy;
            m_cur.free[exp_rd_phy]  = 1'b0;
            m_cur.ready[exp_rd_phy] = 1'b0;
            m_tag[exp_rd_phy]       = ren_rob_tag;
        end
        if (wb_valid) begin
            m_cur.ready[wb_phy] = 1'b1;
            for (int i = 0; i < ck_q.size(); i++) begin
                t = ck_q[i]; t.ready[wb_phy] = 1'b1; ck_q[i] = t;
            end
        end
        if (cm_free_valid && cm_free_phy != 0) begin
            m_cur.free[cm_free_phy] = 1'b1;
            for (int i = 0; i < ck_q.size(); i++) begin
                t = ck_q[i]; t.free[cm_free_phy] = 1'b1; ck_q[i] = t;
            end
        end
        if (res) void'(ck_q.pop_front());
        if (fire && ren_is_branch) ck_q.push_back(m_cur);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        ren_valid = 0; ren_rs_arch = 0; ren_rt_arch = 0; ren_rd_arch = 0;
        ren_uses_rd = 0; ren_is_branch = 0; ren_rob_tag = 0;
        wb_valid = 0; wb_phy = 0; cm_free_valid = 0; cm_free_phy = 0;
        br_valid = 0; br_mispredict = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        ren_rs_arch = 5'd7; ren_rt_arch = 5'd9;
        #1;
        n_checks++; if (rs_phy !== 6'd0 || rs_rdy !== 1'b1 || rs_tag !== 5'd0) begin
            n_errors++; $display("FAIL reset_rs_idle: got phy=%0d rdy=%0d tag=%0d expected 0/1/0", rs_phy, rs_rdy, rs_tag); end
        n_checks++; if (rt_phy !== 6'd0 || rt_rdy !== 1'b1 || rt_tag !== 5'd0) begin
            n_errors++; $display("FAIL reset_rt_idle: got phy=%0d rdy=%0d tag=%0d expected 0/1/0", rt_phy, rt_rdy, rt_tag); end
        n_checks++; if (ckpt_full !== 1'b0) begin
            n_errors++; $display("FAIL reset_ckpt_full: got %0d expected 0", ckpt_full); end
        n_checks++; if (rd_phy !== 6'd32) begin
            n_errors++; $display("FAIL reset_rd_phy: got %0d expected 32", rd_phy); end
        ren_valid = 1;
        #1;
        n_checks++; if (rs_phy !== 6'd7 || rt_phy !== 6'd9 || rs_rdy !== 1'b1) begin
            n_errors++; $display("FAIL reset_identity: got rs=%0d rt=%0d rdy=%0d expected 7 9 1", rs_phy, rt_phy, rs_rdy); end
        drive_idle();
    endtask

    task automatic test_alloc_exhaust();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            ren_valid = 1; ren_uses_rd = 1; ren_rd_arch = 5'(1 + (k % 31));
            #1;
            n_checks++; if (ren_ready !== 1'b1 || rd_phy !== 6'(32 + k)) begin
                n_errors++; $display("FAIL alloc_seq[%0d]: got ready=%0d phy=%0d expected 1 %0d", k, ren_ready, rd_phy, 32 + k); end
            if (k == 31) begin
                n_checks++; if (rd_old_phy !== 6'd32) begin
                    n_errors++; $display("FAIL alloc_old_phy: got %0d expected 32", rd_old_phy); end
            end
            tick();
        end
        ren_rd_arch = 5'd2;
        #1;
        n_checks++; if (ren_ready !== 1'b0) begin
            n_errors++; $display("FAIL alloc_empty_stall: got %0d expected 0", ren_ready); end
        ren_rd_arch = 5'd0;
        #1;
        n_checks++; if (ren_ready !== 1'b1) begin
            n_errors++; $display("FAIL alloc_empty_r0: got %0d expected 1", ren_ready); end
        ren_rd_arch = 5'd2; cm_free_valid = 1; cm_free_phy = 6'd5;
        #1;
        n_checks++; if (ren_ready !== 1'b0) begin
            n_errors++; $display("FAIL free_same_cycle: got %0d expected 0", ren_ready); end
        tick();
        cm_free_valid = 0;
        #1;
        n_checks++; if (ren_ready !== 1'b1 || rd_phy !== 6'd5) begin
            n_errors++; $display("FAIL free_next_cycle: got ready=%0d phy=%0d expected 1 5", ren_ready, rd_phy); end
        tick();
        drive_idle();
    endtask

    task automatic test_rd_zero();
        do_reset();
        ren_valid = 1; ren_uses_rd = 1; ren_rd_arch = 5'd0;
        #1;
        n_checks++; if (ren_ready !== 1'b1 || rd_old_phy !== 6'd0) begin
            n_errors++; $display("FAIL rd0_accept: got ready=%0d old=%0d expected 1 0", ren_ready, rd_old_phy); end
        tick();
        ren_uses_rd = 0; ren_rs_arch = 5'd0; cm_free_valid = 1; cm_free_phy = 6'd0;
        #1;
        n_checks++; if (rd_phy !== 6'd32 || rs_phy !== 6'd0 || rs_rdy !== 1'b1) begin
            n_errors++; $display("FAIL rd0_no_alloc: got rd=%0d rs=%0d rdy=%0d expected 32 0 1", rd_phy, rs_phy, rs_rdy); end
        tick();
        cm_free_valid = 0;
        #1;
        n_checks++; if (rd_phy !== 6'd32) begin
            n_errors++; $display("FAIL free_phy0_ignored: got %0d expected 32", rd_phy); end
        drive_idle();
    endtask

    task automatic test_wb_ready();
        do_reset();
        ren_valid = 1; ren_uses_rd = 1; ren_rd_arch = 5'd3; ren_rob_tag = 5'd7;
        tick();
        ren_uses_rd = 0; ren_rs_arch = 5'd3; ren_rt_arch = 5'd0;
        #1;
        n_checks++; if (rs_phy !== 6'd32 || rs_rdy !== 1'b0 || rs_tag !== 5'd7) begin
            n_errors++; $display("FAIL wb_pending: got phy=%0d rdy=%0d tag=%0d expected 32 0 7", rs_phy, rs_rdy, rs_tag); end
        n_checks++; if (rt_phy !== 6'd0 || rt_rdy !== 1'b1) begin
            n_errors++; $display("FAIL wb_rt_zero: got phy=%0d rdy=%0d expected 0 1", rt_phy, rt_rdy); end
        wb_valid = 1; wb_phy = 6'd32;
        #1;
        n_checks++; if (rs_rdy !== BYP) begin
            n_errors++; $display("FAIL wb_same_cycle: got %0d expected %0d", rs_rdy, BYP); end
        tick();
        wb_valid = 0;
        #1;
        n_checks++; if (rs_rdy !== 1'b1 || rs_tag !== 5'd7) begin
            n_errors++; $display("FAIL wb_next_cycle: got rdy=%0d tag=%0d expected 1 7", rs_rdy, rs_tag); end
        drive_idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        ren_valid = 1; ren_uses_rd = 1; ren_rd_arch = 5'd3;
        tick();
        ren_uses_rd = 0; ren_is_branch = 1;
        tick();
        ren_is_branch = 0; ren_uses_rd = 1; ren_rd_arch = 5'd4;
        #1;
        n_checks++; if (rd_phy !== 6'd33) begin
            n_errors++; $display("FAIL mp_alloc: got %0d expected 33", rd_phy); end
        tick();
        ren_rd_arch = 5'd5; br_valid = 1; br_mispredict = 1;
        #1;
        n_checks++; if (ren_ready !== 1'b0) begin
            n_errors++; $display("FAIL mp_no_rename: got %0d expected 0", ren_ready); end
        tick();
        br_valid = 0; br_mispredict = 0; ren_uses_rd = 0;
        ren_rs_arch = 5'd4; ren_rt_arch = 5'd3;
        #1;
        n_checks++; if (rs_phy !== 6'd4 || rs_rdy !== 1'b1) begin
            n_errors++; $display("FAIL mp_restore_r4: got phy=%0d rdy=%0d expected 4 1", rs_phy, rs_rdy); end
        n_checks++; if (rt_phy !== 6'd32 || rt_rdy !== 1'b0) begin
            n_errors++; $display("FAIL mp_keep_r3: got phy=%0d rdy=%0d expected 32 0", rt_phy, rt_rdy); end
        n_checks++; if (rd_phy !== 6'd33 || ckpt_full !== 1'b0) begin
            n_errors++; $display("FAIL mp_free_back: got rd=%0d full=%0d expected 33 0", rd_phy, ckpt_full); end
        drive_idle();
    endtask

    task automatic test_ckpt_full();
        do_reset();
        br_valid = 1;                  // resolve with no checkpoint: dropped
        tick();
        br_valid = 0;
        for (int i = 0; i < 4; i++) begin
            ren_valid = 1; ren_is_branch = 1;
            tick();
            #1;
            n_checks++; if (ckpt_full !== (i == 3)) begin
                n_errors++; $display("FAIL ckpt_fill[%0d]: got %0d expected %0d", i, ckpt_full, i == 3); end
        end
        #1;
        n_checks++; if (ren_ready !== 1'b0) begin
            n_errors++; $display("FAIL ckpt_5th_stall: got %0d expected 0", ren_ready); end
        ren_is_branch = 0; ren_uses_rd = 1; ren_rd_arch = 5'd6;
        #1;
        n_checks++; if (ren_ready !== 1'b1) begin
            n_errors++; $display("FAIL ckpt_full_nonbranch: got %0d expected 1", ren_ready); end
        ren_uses_rd = 0; ren_is_branch = 1; br_valid = 1;
        #1;
        n_checks++; if (ren_ready !== 1'b0) begin
            n_errors++; $display("FAIL ckpt_full_conservative: got %0d expected 0", ren_ready); end
        tick();
        #1;
        n_checks++; if (ckpt_full !== 1'b0 || ren_ready !== 1'b1) begin
            n_errors++; $display("FAIL ckpt_after_resolve: got full=%0d ready=%0d expected 0 1", ckpt_full, ren_ready); end
        tick();                        // resolve + new branch: count holds at 3
        br_valid = 0;
        #1;
        n_checks++; if (ckpt_full !== 1'b0) begin
            n_errors++; $display("FAIL ckpt_resolve_and_take: got %0d expected 0", ckpt_full); end
        tick();
        #1;
        n_checks++; if (ckpt_full !== 1'b1) begin
            n_errors++; $display("FAIL ckpt_refill: got %0d expected 1", ckpt_full); end
        ren_is_branch = 0;
    endtask

    task automatic test_reset_midstream();
        ren_valid = 1; ren_uses_rd = 1; ren_rd_arch = 5'd9; ren_is_branch = 0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ren_rs_arch = 5'd4; ren_rt_arch = 5'd31; ren_rd_arch = 5'd9;
        #1;
        n_checks++; if (rs_phy !== 6'd4 || rt_phy !== 6'd31 || rs_rdy !== 1'b1) begin
            n_errors++; $display("FAIL rst_mid_identity: got rs=%0d rt=%0d rdy=%0d expected 4 31 1", rs_phy, rt_phy, rs_rdy); end
        n_checks++; if (rd_phy !== 6'd32 || rd_old_phy !== 6'd9 || ckpt_full !== 1'b0) begin
            n_errors++; $display("FAIL rst_mid_state: got rd=%0d old=%0d full=%0d expected 32 9 0", rd_phy, rd_old_phy, ckpt_full); end
        drive_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst           = ($urandom_range(0, 199) == 0);
            ren_valid     = ($urandom_range(0, 3) != 0);
            ren_rs_arch   = 5'($urandom);
            ren_rt_arch   = 5'($urandom);
            ren_rd_arch   = 5'($urandom);
            ren_uses_rd   = ($urandom_range(0, 9) < 7);
            ren_is_branch = ($urandom_range(0, 9) < 2);
            ren_rob_tag   = 5'($urandom);
            wb_valid      = ($urandom_range(0, 9) < 4);
            wb_phy        = 6'($urandom);
            cm_free_valid = ($urandom_range(0, 9) < 3);
            cm_free_phy   = 6'($urandom);
            br_valid      = ($urandom_range(0, 9) < 2);
            br_mispredict = ($urandom_range(0, 3) == 0);
            #1;
            model_eval();
            n_checks++; if (ren_ready !== exp_ready || ckpt_full !== exp_full) begin
                n_errors++; $display("FAIL rnd_ctrl[%0d]: got ready=%0d full=%0d expected %0d %0d", c, ren_ready, ckpt_full, exp_ready, exp_full); end
            n_checks++; if (rs_phy !== exp_rs_phy || rs_rdy !== exp_rs_rdy || rs_tag !== exp_rs_tag) begin
                n_errors++; $display("FAIL rnd_rs[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", c, rs_phy, rs_rdy, rs_tag, exp_rs_phy, exp_rs_rdy, exp_rs_tag); end
            n_checks++; if (rt_phy !== exp_rt_phy || rt_rdy !== exp_rt_rdy || rt_tag !== exp_rt_tag) begin
                n_errors++; $display("FAIL rnd_rt[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", c, rt_phy, rt_rdy, rt_tag, exp_rt_phy, exp_rt_rdy, exp_rt_tag); end
            n_checks++; if (rd_old_phy !== exp_old || (exp_found && rd_phy !== exp_rd_phy)) begin
                n_errors++; $display("FAIL rnd_rd[%0d]: got rd=%0d old=%0d expected %0d %0d", c, rd_phy, rd_old_phy, exp_rd_phy, exp_old); end
            tick();
        end
        rst = 1'b0;
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        tick();
        test_reset();
        test_alloc_exhaust();
        test_rd_zero();
        test_wb_ready();
        test_mispredict();
        test_ckpt_full();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
